// File: rtl/muldiv_unit_if.sv
// ============================================================================
// Module   : muldiv_unit_if
// Purpose  : Issue/result handshake bundle between the execute stage and
//            the multi-cycle multiply/divide unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface muldiv_unit_if #(
    parameter int Bit_Width = 32
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [Bit_Width-1:0] A;
    logic [Bit_Width-1:0] B;
    logic [2:0]           md_sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [Bit_Width-1:0] md_result;

    modport master (
        output flush, in_valid, A, B, md_sel, out_ready,
        input  in_ready, out_valid, md_result
    );

    modport slave (
        input  flush, in_valid, A, B, md_sel, out_ready,
        output in_ready, out_valid, md_result
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : RV32M multiply/divide, one result bit per cycle (shift-add
//            multiply, restoring divide) with valid/ready handshakes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int Bit_Width = 32
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    muldiv_unit_if.slave   bus
);
    localparam int W     = Bit_Width;
    localparam int CNT_W = $clog2(Bit_Width);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_a_mag;
    logic [W-1:0]     r_b_mag;
    logic [2:0]       r_sel;
    logic             r_sa;
    logic             r_sb;
    logic [2*W-1:0]   r_acc;
    logic [W-1:0]     r_result;

    // ---------------- accept-time decode ----------------
    logic         w_accept;
    logic         w_is_div;
    logic         w_a_signed;
    logic         w_b_signed;
    logic         w_sa;
    logic         w_sb;
    logic [W-1:0] w_a_mag;
    logic [W-1:0] w_b_mag;
    logic         w_div0;
    logic         w_ovf;
    logic         w_special;
    logic [W-1:0] w_special_res;

    assign w_accept   = bus.in_valid && (r_state == S_IDLE) && !bus.flush;
    assign w_is_div   = bus.md_sel[2];
    assign w_a_signed = (bus.md_sel == 3'd1) || (bus.md_sel == 3'd2) ||
                        (bus.md_sel == 3'd4) || (bus.md_sel == 3'd6);
    assign w_b_signed = (bus.md_sel == 3'd1) || (bus.md_sel == 3'd4) ||
                        (bus.md_sel == 3'd6);
    assign w_sa       = w_a_signed && bus.A[W-1];
    assign w_sb       = w_b_signed && bus.B[W-1];
    assign w_a_mag    = w_sa ? -bus.A : bus.A;
    assign w_b_mag    = w_sb ? -bus.B : bus.B;
    assign w_div0     = w_is_div && (bus.B == '0);
    assign w_ovf      = w_is_div && !bus.md_sel[0] &&
                        (bus.A == {1'b1, {(W-1){1'b0}}}) && (bus.B == '1);
    assign w_special  = w_div0 || w_ovf;

    // md_sel[1] selects remainder, md_sel[0] selects unsigned
    always_comb begin
        w_special_res = '0;
        if (w_div0)
            w_special_res = bus.md_sel[1] ? bus.A : '1;
        else if (w_ovf)
            w_special_res = bus.md_sel[1] ? '0 : bus.A;
    end

    // ---------------- iteration step ----------------
    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_mul_next;
    logic [W:0]     w_div_shift;
    logic [W:0]     w_div_diff;
    logic [2*W-1:0] w_div_next;
    logic [2*W-1:0] w_step;

    // Multiply: {hi, multiplier} shifts right, multiplicand added into hi.
    assign w_mul_sum   = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_a_mag} : '0);
    assign w_mul_next  = {w_mul_sum, r_acc[W-1:1]};
    // Divide: {remainder, quotient} shifts left, quotient bits enter at LSB.
    assign w_div_shift = r_acc[2*W-1:W-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_b_mag};
    assign w_div_next  = w_div_diff[W] ? {w_div_shift[W-1:0], r_acc[W-2:0], 1'b0}
                                       : {w_div_diff[W-1:0],  r_acc[W-2:0], 1'b1};
    assign w_step      = r_sel[2] ? w_div_next : w_mul_next;

    // ---------------- sign correction / result select ----------------
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quot;
    logic [W-1:0]   w_rem;
    logic [W-1:0]   w_fix_res;

    assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_quot = r_acc[W-1:0];
    assign w_rem  = r_acc[2*W-1:W];

    always_comb begin
        w_fix_res = '0;
        case (r_sel)
            3'd0:                w_fix_res = w_prod[W-1:0];
            3'd1, 3'd2, 3'd3:    w_fix_res = w_prod[2*W-1:W];
            3'd4, 3'd5:          w_fix_res = (r_sa ^ r_sb) ? -w_quot : w_quot;
            default:             w_fix_res = r_sa ? -w_rem : w_rem;
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_BUSY;
            S_BUSY: if (r_cnt == CNT_W'(W-1)) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.flush)
            w_next = S_IDLE;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_a_mag  <= '0;
            r_b_mag  <= '0;
            r_sel    <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_a_mag <= w_a_mag;
                        r_b_mag <= w_b_mag;
                        r_sel   <= bus.md_sel;
                        r_sa    <= w_sa;
                        r_sb    <= w_sb;
                        r_acc   <= {{W{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                        if (w_special)
                            r_result <= w_special_res;
                    end
                end
                S_BUSY: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX:   r_result <= w_fix_res;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.md_result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit at widths 32 and 8.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.Bit_Width(32)) if32();
    muldiv_unit_if #(.Bit_Width(8))  if8();

    muldiv_unit #(.Bit_Width(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
    muldiv_unit #(.Bit_Width(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    // One shared driver; sel8 routes it to the 8-bit or the 32-bit unit.
    logic        sel8 = 1'b0;
    logic        tb_valid = 1'b0;
    logic        tb_flush = 1'b0;
    logic        tb_oready = 1'b0;
    logic [31:0] tb_a = '0;
    logic [31:0] tb_b = '0;
    logic [2:0]  tb_sel = '0;

    assign if32.in_valid  = tb_valid & ~sel8;
    assign if32.flush     = tb_flush;
    assign if32.out_ready = tb_oready & ~sel8;
    assign if32.A         = tb_a;
    assign if32.B         = tb_b;
    assign if32.md_sel    = tb_sel;
    assign if8.in_valid   = tb_valid & sel8;
    assign if8.flush      = tb_flush;
    assign if8.out_ready  = tb_oready & sel8;
    assign if8.A          = tb_a[7:0];
    assign if8.B          = tb_b[7:0];
    assign if8.md_sel     = tb_sel;

    logic        w_rdy;
    logic        w_val;
    logic [31:0] w_res;
    assign w_rdy = sel8 ? if8.in_ready  : if32.in_ready;
    assign w_val = sel8 ? if8.out_valid : if32.out_valid;
    assign w_res = sel8 ? {24'b0, if8.md_result} : if32.md_result;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ext(input logic [31:0] v, input int w, input bit s);
        logic [63:0] m;
        logic [63:0] r;
        m = (64'd1 << w) - 64'd1;
        r = {32'b0, v} & m;
        if (s && r[w-1]) r = r | ~m;
        return r;
    endfunction

    function automatic logic [31:0] ref_md(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input logic [2:0] op);
        logic [63:0] m;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] r;
        longint      sa;
        longint      sb;
        bit          as_;
        bit          bs_;
        m   = (64'd1 << w) - 64'd1;
        as_ = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        bs_ = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        ea  = ext(a, w, as_);
        eb  = ext(b, w, bs_);
        sa  = $signed(ea);
        sb  = $signed(eb);
        case (op)
            3'd0:             r = ea * eb;
            3'd1, 3'd2, 3'd3: r = (ea * eb) >> w;
            default: begin
                if (eb == 64'd0)  r = op[1] ? ea : 64'hFFFF_FFFF_FFFF_FFFF;
                else if (op[1])   r = 64'(sa % sb);
                else              r = 64'(sa / sb);
            end
        endcase
        return 32'(r & m);
    endfunction

    function automatic bit is_special(input int w, input logic [31:0] a,
                                      input logic [31:0] b, input logic [2:0] op);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        if (!op[2]) return 1'b0;
        if (({32'b0, b} & m) == 64'd0) return 1'b1;
        return !op[0] && (({32'b0, a} & m) == (64'd1 << (w - 1))) && (({32'b0, b} & m) == m);
    endfunction

    function automatic logic [31:0] rand_opnd(input int w);
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd1 << (w - 1);
            3:       return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input string tag);
        int n;
        n = 0;
        while (!w_rdy && n < 200) begin @(negedge clk); n++; end
        chk({tag, "_rdy"}, 64'(w_rdy), 64'd1);
        tb_a = a; tb_b = b; tb_sel = op; tb_valid = 1'b1;
        @(negedge clk);
        tb_valid = 1'b0;
        tb_a = $urandom; tb_b = $urandom; tb_sel = 3'($urandom);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [31:0] exp, input int exp_lat, input int stall,
                         input string tag);
        int          lat;
        logic [31:0] held;
        issue(a, b, op, tag);
        lat = 1;
        while (!w_val && lat < 200) begin @(negedge clk); lat++; end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, 64'(w_res), 64'(exp));
        chk({tag, "_busy_rdy"}, 64'(w_rdy), 64'd0);
        held = w_res;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_hold_val"}, 64'(w_val), 64'd1);
            chk({tag, "_hold_res"}, 64'(w_res), 64'(held));
            chk({tag, "_hold_rdy"}, 64'(w_rdy), 64'd0);
        end
        tb_oready = 1'b1;
        @(negedge clk);
        tb_oready = 1'b0;
        chk({tag, "_idle_rdy"}, 64'(w_rdy), 64'd1);
        chk({tag, "_idle_val"}, 64'(w_val), 64'd0);
    endtask

    task automatic rand_ops(input bit w8, input int n);
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        w    = w8 ? 8 : 32;
        sel8 = w8;
        for (int k = 0; k < n; k++) begin
            a  = rand_opnd(w);
            b  = rand_opnd(w);
            op = 3'($urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(a, b, op, ref_md(w, a, b, op),
                  is_special(w, a, b, op) ? 1 : w + 2,
                  int'($urandom_range(0, 3)), w8 ? "rnd8" : "rnd32");
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int seen;
        repeat (2) @(negedge clk);
        chk("rst_val32", 64'(if32.out_valid), 64'd0);
        chk("rst_res32", 64'(if32.md_result), 64'd0);
        chk("rst_val8",  64'(if8.out_valid),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy32", 64'(if32.in_ready), 64'd1);

        sel8 = 1'b0;
        do_op(32'hFFFF_FFFE, 32'd3, 3'd0, 32'hFFFF_FFFA, 34, 0, "mul");
        do_op(32'hFFFF_FFFE, 32'd3, 3'd1, 32'hFFFF_FFFF, 34, 0, "mulh");
        do_op(32'hFFFF_FFFE, 32'd3, 3'd3, 32'h0000_0002, 34, 0, "mulhu");
        do_op(32'hFFFF_FFFE, 32'd3, 3'd2, 32'hFFFF_FFFF, 34, 0, "mulhsu");
        do_op(32'hFFFF_FFF9, 32'd2, 3'd4, 32'hFFFF_FFFD, 34, 0, "div");
        do_op(32'hFFFF_FFF9, 32'd2, 3'd6, 32'hFFFF_FFFF, 34, 0, "rem");
        do_op(32'hFFFF_FFF9, 32'd2, 3'd5, 32'h7FFF_FFFC, 34, 0, "divu");
        do_op(32'hFFFF_FFF9, 32'd2, 3'd7, 32'h0000_0001, 34, 0, "remu");
        do_op(32'd7, 32'd0, 3'd5, 32'hFFFF_FFFF, 1, 0, "divu0");
        do_op(32'd7, 32'd0, 3'd7, 32'd7,         1, 0, "remu0");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 32'h8000_0000, 1, 0, "div_ovf");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 3'd6, 32'd0,         1, 0, "rem_ovf");
        do_op(32'd100, 32'd7, 3'd4, 32'd14, 34, 5, "bp");

        // Flush at BUSY cycle 10
        issue(32'h1234_5678, 32'h9ABC_DEF0, 3'd3, "fl");
        repeat (9) @(negedge clk);
        tb_flush = 1'b1;
        @(negedge clk);
        tb_flush = 1'b0;
        chk("flush_rdy", 64'(w_rdy), 64'd1);
        chk("flush_val", 64'(w_val), 64'd0);
        seen = 0;
        repeat (40) begin @(negedge clk); if (w_val) seen++; end
        chk("flush_noval", 64'(seen), 64'd0);
        do_op(32'd6, 32'd7, 3'd0, 32'd42, 34, 0, "after_flush");

        // Flush beats in_valid in the same cycle
        tb_a = 32'd7; tb_b = 32'd0; tb_sel = 3'd5; tb_valid = 1'b1; tb_flush = 1'b1;
        @(negedge clk);
        tb_valid = 1'b0; tb_flush = 1'b0;
        chk("flush_acc_rdy", 64'(w_rdy), 64'd1);
        chk("flush_acc_val", 64'(w_val), 64'd0);

        // Flush while DONE discards the result
        issue(32'd7, 32'd0, 3'd5, "fl_done");
        chk("fl_done_val", 64'(w_val), 64'd1);
        tb_flush = 1'b1;
        @(negedge clk);
        tb_flush = 1'b0;
        chk("fl_done_drop", 64'(w_val), 64'd0);
        chk("fl_done_rdy",  64'(w_rdy), 64'd1);

        // Asynchronous reset mid-BUSY
        do_op(32'd6, 32'd7, 3'd0, 32'd42, 34, 0, "pre_rst");
        issue(32'd6, 32'd7, 3'd0, "rst_op");
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_val", 64'(w_val), 64'd0);
        chk("arst_res", 64'(w_res), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rdy", 64'(w_rdy), 64'd1);
        seen = 0;
        repeat (40) begin @(negedge clk); if (w_val) seen++; end
        chk("arst_noval", 64'(seen), 64'd0);

        // Width-8 directed boundary cases
        sel8 = 1'b1;
        do_op(32'h80, 32'hFF, 3'd4, 32'h80, 1, 0, "div8_ovf");
        do_op(32'hF9, 32'h02, 3'd6, 32'hFF, 10, 0, "rem8");
        do_op(32'hFE, 32'h03, 3'd3, 32'h02, 10, 0, "mulhu8");

        rand_ops(1'b0, 800);
        rand_ops(1'b1, 1500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
